// File: rtl/mem_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_bus_master                                                  |
// | Purpose  : Clocked valid/ready initiator for an asynchronous-strobe RAM.   |
// |            Sequences address/data setup, write pulse, hold and read       |
// |            access/turnaround on a shared tri-state data bus.              |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst              clock; asynchronous active-high reset              |
// |   req_valid/req_ready   request handshake (ready only while idle)          |
// |   req_we/addr/wdata     request fields, latched on acceptance              |
// |   resp_valid            one-cycle completion pulse                         |
// |   resp_we               type of the completed transaction                  |
// |   resp_rdata            last read data, held until the next read completes |
// |   mem_addr              RAM address (registered)                           |
// |   mem_read/mem_write    RAM level strobes (registered, glitch-free)        |
// |   mem_data              shared bidirectional RAM data bus                  |
// +----------------------------------------------------------------------------+
module mem_bus_master #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  inout  wire  [DATA_W-1:0] mem_data
);

  // Terminal counts of the 4-bit phase counter (both waits are 1..15).
  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_PULSE  = 3'd2,
    W_HOLD   = 3'd3,
    R_ACCESS = 3'd4,
    R_TURN   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                oe_q, oe_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_we_q, resp_we_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_we_d    = resp_we_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          cnt_d  = 4'd0;
          if (req_we) begin
            wdata_d = req_wdata;
            state_d = W_SETUP;
          end else begin
            state_d = R_ACCESS;
          end
        end
      end
      W_SETUP: begin
        cnt_d   = 4'd0;
        state_d = W_PULSE;
      end
      W_PULSE: begin
        if (cnt_q == WR_LAST) begin
          state_d = W_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      W_HOLD: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_we_d    = 1'b1;
      end
      R_ACCESS: begin
        // The RAM has had the full access window; capture on this edge.
        if (cnt_q == RD_LAST) begin
          rdata_d = mem_data;
          state_d = R_TURN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      R_TURN: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_we_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes and bus enable are decoded from the next state and registered,
    // so they change cleanly on the clock edge together with the state.
    read_d  = (state_d == R_ACCESS);
    write_d = (state_d == W_PULSE);
    oe_d    = (state_d == W_SETUP) || (state_d == W_PULSE) || (state_d == W_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      oe_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      oe_q         <= oe_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_we    = resp_we_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_read   = read_q;
  assign mem_write  = write_q;
  assign mem_data   = oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_bus_master                                               |
// | Purpose  : Self-checking bench for mem_bus_master. Three instances with    |
// |            different RD_WAIT/WR_PULSE run the same sequence against a      |
// |            strobe RAM model; a scoreboard queue holds expected responses   |
// |            and the expected per-cycle strobe/bus timeline.                 |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_mem_bus_master;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         acc;
  } txn_t;

  logic clk;
  int   cyc;
  int   n_checks;
  int   n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int G  = g;
    localparam int RD = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int WP = (g == 0) ? 1 : (g == 1) ? 3 : 2;

    logic       rst;
    logic       req_valid, req_ready, req_we;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid, resp_we;
    logic [7:0] resp_rdata;
    logic [4:0] mem_addr;
    logic       mem_read, mem_write;
    tri1  [7:0] mem_data;
    logic [7:0] ram [32];
    logic       b2b;
    logic       done;

    mem_bus_master #(
      .ADDR_W(5), .DATA_W(8), .RD_WAIT(RD), .WR_PULSE(WP)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_we(resp_we), .resp_rdata(resp_rdata),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_data(mem_data)
    );

    // Strobe RAM: captures on rising write, drives the bus while read is high.
    assign mem_data = mem_read ? ram[mem_addr] : 8'bz;
    initial begin
      for (int i = 0; i < 32; i++) ram[i] = 8'(i * 7 + 3);
      forever begin
        @(posedge mem_write);
        ram[mem_addr] = mem_data;
      end
    end

    function automatic string tg(input string s);
      return $sformatf("u%0d.%s", G, s);
    endfunction

    // Scoreboard / timeline model, sampled on the falling edge.
    initial begin : p_mon
      txn_t       q[$];
      txn_t       h, e;
      logic [7:0] shadow [32];
      logic [7:0] exp_hold;
      logic       ex_r, ex_w, ex_oe, busy, prev_b2b, prev_we;
      int         k, prev_acc;
      for (int i = 0; i < 32; i++) shadow[i] = 8'(i * 7 + 3);
      exp_hold = 8'h00;
      prev_b2b = 1'b0;
      prev_we  = 1'b0;
      prev_acc = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          exp_hold = 8'h00;
          prev_b2b = 1'b0;
        end else begin
          if (resp_valid) begin
            if (q.size() == 0) begin
              check_eq(tg("unexpected_resp"), 32'd1, 32'd0);
            end else begin
              h = q.pop_front();
              check_eq(tg("resp_we"), 32'(resp_we), 32'(h.we));
              check_eq(tg("latency"), 32'(cyc - h.acc), h.we ? 32'(WP + 2) : 32'(RD + 1));
              if (h.we) begin
                check_eq(tg("rdata_after_wr"), 32'(resp_rdata), 32'(exp_hold));
                shadow[h.addr] = h.wdata;
              end else begin
                check_eq(tg("rdata"), 32'(resp_rdata), 32'(h.rdata));
                exp_hold = h.rdata;
              end
            end
          end

          ex_r = 1'b0; ex_w = 1'b0; ex_oe = 1'b0; busy = 1'b0;
          if (q.size() > 0) begin
            h = q[0];
            k = cyc - h.acc;
            if (k > 40) begin
              check_eq(tg("resp_timeout"), 32'(k), 32'd0);
              q.delete();
            end else begin
              busy = 1'b1;
              if (h.we) begin
                ex_oe = (k <= WP + 1);
                ex_w  = (k >= 1) && (k <= WP);
              end else begin
                ex_r  = (k <= RD - 1);
              end
            end
          end
          check_eq(tg("mem_read"),  32'(mem_read),  32'(ex_r));
          check_eq(tg("mem_write"), 32'(mem_write), 32'(ex_w));
          check_eq(tg("req_ready"), 32'(req_ready), 32'(!busy));
          if (busy) check_eq(tg("mem_addr"), 32'(mem_addr), 32'(h.addr));
          if (ex_oe)     check_eq(tg("bus_wdata"),   32'(mem_data), 32'(h.wdata));
          else if (ex_r) check_eq(tg("bus_rdata"),   32'(mem_data), 32'(h.rdata));
          else           check_eq(tg("bus_release"), 32'(mem_data), 32'hFF);
          if (!busy || h.we) check_eq(tg("rdata_hold"), 32'(resp_rdata), 32'(exp_hold));

          if (req_valid && req_ready) begin
            e.we    = req_we;
            e.addr  = req_addr;
            e.wdata = req_wdata;
            e.rdata = req_we ? 8'h00 : shadow[req_addr];
            e.acc   = cyc + 1;
            if (b2b && prev_b2b)
              check_eq(tg("b2b_gap"), 32'(e.acc - prev_acc), prev_we ? 32'(WP + 3) : 32'(RD + 2));
            prev_acc = e.acc;
            prev_we  = req_we;
            prev_b2b = b2b;
            q.push_back(e);
          end
        end
      end
    end

    task automatic send(input logic we, input logic [4:0] a, input logic [7:0] d);
      logic ok;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (req_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        check_eq(tg("ready_timeout"), 32'd0, 32'd1);
        req_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic chk_reset_vals(input string s);
      check_eq(tg({s, "_ready"}),      32'(req_ready),  32'd1);
      check_eq(tg({s, "_resp_valid"}), 32'(resp_valid), 32'd0);
      check_eq(tg({s, "_resp_we"}),    32'(resp_we),    32'd0);
      check_eq(tg({s, "_resp_rdata"}), 32'(resp_rdata), 32'd0);
      check_eq(tg({s, "_mem_addr"}),   32'(mem_addr),   32'd0);
      check_eq(tg({s, "_mem_read"}),   32'(mem_read),   32'd0);
      check_eq(tg({s, "_mem_write"}),  32'(mem_write),  32'd0);
      check_eq(tg({s, "_bus"}),        32'(mem_data),   32'hFF);
    endtask

    task automatic mid_reset(input string s);
      rst       = 1'b1;
      req_valid = 1'b0;
      #1;
      chk_reset_vals(s);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(5);
    endtask

    initial begin : p_seq
      done      = 1'b0;
      b2b       = 1'b0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst = 1'b0;
      idle(2);

      // Write then read back.
      send(1'b1, 5'd3, 8'hA5);  idle(10);
      send(1'b0, 5'd3, 8'h00);  idle(10);

      // Back-to-back burst with req_valid held high.
      b2b = 1'b1;
      for (int i = 0; i < 8; i++) send(1'b1, 5'(i), 8'(i * 17));
      for (int i = 0; i < 8; i++) send(1'b0, 5'(i), 8'h00);
      b2b = 1'b0;
      idle(10);

      // Read data must survive a following write.
      send(1'b0, 5'd5, 8'h00);  idle(10);
      send(1'b1, 5'd5, 8'h66);  idle(10);
      check_eq(tg("rdata_kept"), 32'(resp_rdata), 32'h55);

      // Reset during R_ACCESS.
      send(1'b0, 5'd10, 8'h00);
      #2;
      check_eq(tg("in_read"), 32'(mem_read), 32'd1);
      mid_reset("rst_rd");

      // Reset during W_PULSE.
      send(1'b1, 5'd20, 8'h3C);
      @(posedge clk);
      #2;
      check_eq(tg("in_pulse"), 32'(mem_write), 32'd1);
      mid_reset("rst_wr");

      // Untouched and previously written addresses after the resets.
      send(1'b0, 5'd10, 8'h00); idle(10);
      send(1'b0, 5'd3,  8'h00); idle(10);
      done = 1'b1;
    end
  end

  initial begin : p_main
    for (int i = 0; i < 20000; i++) begin
      if (g_inst[0].done && g_inst[1].done && g_inst[2].done) break;
      @(posedge clk);
    end
    if (!(g_inst[0].done && g_inst[1].done && g_inst[2].done))
      check_eq("global_timeout", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
